// File: rtl/vpe_pkg.sv
// Shared constants and FSM encoding for the VPE bias fetch path.
package vpe_pkg;
  localparam int VPE_BIAS_W     = 64;
  localparam int VPE_ADDR_W     = 8;
  localparam int VPE_ROM_LAT    = 2;
  localparam int VPE_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/vpe_bias_skid_fifo.sv
// Small sync FIFO that absorbs ROM returns; push+pop when empty passes the word straight through.
module vpe_bias_skid_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wr_data,
  input  logic             pop,
  output logic [W-1:0]     rd_data,
  output logic             full,
  output logic             empty,
  output logic [OCC_W-1:0] occ
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        wptr, rptr;
  logic [OCC_W-1:0]        cnt;
  logic                    pass, wr_en, rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full    = (cnt == OCC_W'(DEPTH));
    empty   = (cnt == '0);
    occ     = cnt;
    pass    = push && pop && empty;
    wr_en   = push && !pass && (!full || pop);
    rd_en   = pop && !empty;
    rd_data = empty ? wr_data : mem[rptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) wptr <= ptr_inc(wptr);
      if (rd_en) rptr <= ptr_inc(rptr);
      cnt <= cnt + OCC_W'(wr_en) - OCC_W'(rd_en);
    end
  end

  // Storage needs no reset: it is only visible when the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end
endmodule

// File: rtl/vpe_bias_fetch_ctrl.sv
// Streams a (base, count) run of bias ROM words to the VPE; credits cover ROM latency so no word drops.
module vpe_bias_fetch_ctrl
  import vpe_pkg::*;
#(
  parameter int BIAS_W     = VPE_BIAS_W,
  parameter int ADDR_W     = VPE_ADDR_W,
  parameter int ROM_LAT    = VPE_ROM_LAT,
  parameter int FIFO_DEPTH = VPE_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_count,
  output logic              rom_rd_valid,
  output logic [ADDR_W-1:0] rom_raddr,
  input  logic [BIAS_W-1:0] rom_data,
  output logic              bias_valid,
  input  logic              bias_ready,
  output logic [BIAS_W-1:0] bias_data,
  output logic              bias_last,
  output logic              busy,
  output logic              done
);
  localparam int IF_W  = $clog2(ROM_LAT + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = ((IF_W > OCC_W) ? IF_W : OCC_W) + 1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     count_q, issued, accepted;
  logic [IF_W-1:0]     in_flight;
  logic [ROM_LAT-1:0]  vld_pipe, last_pipe;
  logic [SUM_W-1:0]    credit_used;
  logic [OCC_W-1:0]    occ;
  logic [BIAS_W:0]     fifo_head;
  logic [BIAS_W-1:0]   head_data;
  logic                head_last;
  logic                cmd_fire, rd_issue, issue_last, push, pop, full, empty;

  always_comb begin
    cmd_ready    = (state == ST_IDLE);
    busy         = (state != ST_IDLE);
    done         = (state == ST_DONE);
    cmd_fire     = cmd_valid && cmd_ready;
    push         = vld_pipe[ROM_LAT-1];
    head_data    = fifo_head[BIAS_W-1:0];
    head_last    = fifo_head[BIAS_W];
    bias_valid   = !empty;
    bias_data    = bias_valid ? head_data : '0;
    bias_last    = bias_valid && head_last;
    pop          = bias_valid && bias_ready;
    // Reads still in the ROM pipe count against FIFO space until they land.
    credit_used  = SUM_W'(in_flight) + SUM_W'(occ);
    issue_last   = (issued == count_q - (ADDR_W + 1)'(1));
    rd_issue     = (state == ST_FETCH) && (issued < count_q) &&
                   (credit_used < SUM_W'(FIFO_DEPTH));
    rom_rd_valid = rd_issue;
    rom_raddr    = base_q + issued[ADDR_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_fire) state_nxt = (cmd_count == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: if (rd_issue && issue_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop && head_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      issued    <= '0;
      accepted  <= '0;
      in_flight <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        base_q   <= cmd_base;
        count_q  <= cmd_count;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (rd_issue) issued   <= issued + (ADDR_W + 1)'(1);
        if (pop)      accepted <= accepted + (ADDR_W + 1)'(1);
      end
      in_flight   <= in_flight + IF_W'(rd_issue) - IF_W'(push);
      vld_pipe[0]  <= rd_issue;
      last_pipe[0] <= rd_issue && issue_last;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  vpe_bias_skid_fifo #(
    .W     (BIAS_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({last_pipe[ROM_LAT-1], rom_data}),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (full),
    .empty   (empty),
    .occ     (occ)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));
  a_last_index:  assert property (@(posedge clk) disable iff (!rst)
                   pop |-> (head_last == (accepted == count_q - (ADDR_W + 1)'(1))));
endmodule

// File: tb/tb_vpe_bias_fetch_ctrl.sv
// Scoreboard bench: commands queue expected reads/words, a negedge monitor pops and compares.
module tb_vpe_bias_fetch_ctrl;
  logic        clk = 0, rst = 0;
  logic        cmd_valid = 0, cmd_ready;
  logic [7:0]  cmd_base = '0;
  logic [8:0]  cmd_count = '0;
  logic        rom_rd_valid;
  logic [7:0]  rom_raddr;
  logic [63:0] rom_data, rom_s1;
  logic        bias_valid, bias_ready = 1;
  logic [63:0] bias_data;
  logic        bias_last, busy, done;

  typedef struct packed { logic [63:0] d; logic l; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] addr_q[$];
  exp_t       mon_e;

  int   checks = 0, errors = 0, cyc = 0;
  int   rd_cnt, word_cnt, last_cnt, done_cnt, rd_first, rd_last, w_first, w_last, done_cyc;
  bit   rmode = 0, hold_pend = 0;
  logic [63:0] hold_d;
  logic        hold_l;
  logic [3:0]  pat = 4'b1001;
  int          ph = 0;

  vpe_bias_fetch_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .rom_rd_valid(rom_rd_valid),
    .rom_raddr(rom_raddr), .rom_data(rom_data), .bias_valid(bias_valid),
    .bias_ready(bias_ready), .bias_data(bias_data), .bias_last(bias_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rom_fn(input logic [7:0] a);
    return {a, 8'h5A, ~a, 8'hC3, a ^ 8'h3C, 8'h96, ~a ^ 8'h0F, a};
  endfunction

  // Two-cycle ROM: address register then output register.
  always @(posedge clk) begin
    rom_s1   <= rom_fn(rom_raddr);
    rom_data <= rom_s1;
  end

  always @(posedge clk) begin
    #1;
    if (rmode) begin
      bias_ready = pat[ph];
      ph = (ph + 1) % 4;
    end else bias_ready = 1;
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) hold_pend = 0;
    else begin
      if (hold_pend) begin
        chk("hold_valid", 64'(bias_valid), 1);
        chk("hold_data", bias_data, hold_d);
        chk("hold_last", 64'(bias_last), 64'(hold_l));
      end
      hold_pend = bias_valid && !bias_ready;
      hold_d    = bias_data;
      hold_l    = bias_last;
      if (rom_rd_valid) begin
        if (rd_cnt == 0) rd_first = cyc;
        rd_last = cyc;
        rd_cnt++;
        if (addr_q.size() == 0) chk("raddr_unexpected", 1, 0);
        else chk("raddr", 64'(rom_raddr), 64'(addr_q.pop_front()));
      end
      if (bias_valid && bias_ready) begin
        if (word_cnt == 0) w_first = cyc;
        w_last = cyc;
        word_cnt++;
        if (bias_last) last_cnt++;
        if (exp_q.size() == 0) chk("word_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("bias_data", bias_data, mon_e.d);
          chk("bias_last", 64'(bias_last), 64'(mon_e.l));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    rd_cnt = 0; word_cnt = 0; last_cnt = 0; done_cnt = 0;
  endtask

  task automatic run(input logic [7:0] b, input int c, input bit rm, input bit tim, input int stray);
    int   acc, n;
    exp_t e;
    rmode = rm;
    clear_stats();
    for (int i = 0; i < c; i++) begin
      addr_q.push_back(b + 8'(i));
      e.d = rom_fn(b + 8'(i));
      e.l = (i == c - 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready), 1);
    cmd_valid = 1; cmd_base = b; cmd_count = 9'(c); acc = cyc;
    @(posedge clk); #1;
    if (stray > 0) begin
      cmd_base = 8'h77; cmd_count = 9'd3;
      repeat (stray) @(posedge clk);
      #1;
    end
    cmd_valid = 0;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    @(negedge clk); #1;
    chk("cmd_ready_after_done", 64'(cmd_ready), 1);
    chk("busy_after_done", 64'(busy), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("done_once", 64'(done_cnt), 1);
    chk("word_count", 64'(word_cnt), 64'(c));
    chk("read_count", 64'(rd_cnt), 64'(c));
    chk("last_count", 64'(last_cnt), (c != 0) ? 64'd1 : 64'd0);
    chk("exp_left", 64'(exp_q.size()), 0);
    if (tim) begin
      chk("done_latency", 64'(done_cyc - acc), (c == 0) ? 64'd1 : 64'(c + 4));
      if (c > 0) begin
        chk("first_read", 64'(rd_first - acc), 1);
        chk("read_span", 64'(rd_last - rd_first), 64'(c - 1));
        chk("first_word", 64'(w_first - acc), 4);
        chk("word_span", 64'(w_last - w_first), 64'(c - 1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_rd_valid", 64'(rom_rd_valid), 0);
    chk("rst_raddr", 64'(rom_raddr), 0);
    chk("rst_bias_valid", 64'(bias_valid), 0);
    chk("rst_bias_data", bias_data, 0);
    chk("rst_bias_last", 64'(bias_last), 0);
    @(posedge clk); #1 rst = 1;

    run(8'h10, 4, 0, 1, 0);
    run(8'hFE, 4, 0, 1, 3);
    run(8'h30, 8, 1, 0, 0);
    chk("read_stalled", 64'((rd_last - rd_first) > 7), 1);
    run(8'h55, 0, 0, 1, 0);

    // Abort a count=16 command with reset one read in.
    rmode = 0;
    clear_stats();
    for (int i = 0; i < 16; i++) addr_q.push_back(8'h40 + 8'(i));
    @(negedge clk);
    cmd_valid = 1; cmd_base = 8'h40; cmd_count = 9'd16;
    @(posedge clk); #1 cmd_valid = 0;
    @(posedge clk); #2 rst = 0;
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_cmd_ready", 64'(cmd_ready), 1);
    chk("abort_rd_valid", 64'(rom_rd_valid), 0);
    chk("abort_bias_valid", 64'(bias_valid), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_reads_seen", 64'(rd_cnt), 1);
    addr_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    clear_stats();
    repeat (6) @(negedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 0);
    chk("abort_no_words", 64'(word_cnt), 0);
    run(8'h20, 2, 0, 1, 0);

    run(8'h00, 256, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
